adc_temp_reader: RTL

ADC_TEMP_READER -- requirements
Module: adc_temp_reader

---
 rtl/adc_temp_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adc_temp_reader.sv
// rtl/adc_temp_reader.sv - serial thermocouple ADC reader with averaging and saturation to 999 C
module adc_temp_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 12_500_000,
  parameter int AVG_LOG2      = 2
) (
  input  logic       clock,
  input  logic       reset_sw_n,
  input  logic       sample_en,
  input  logic       adc_miso,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic [9:0] temp_out,
  output logic       temp_valid,
  output logic       sensor_fault
);

  localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int AW = 10 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(1 << AVG_LOG2);
  localparam logic [AW-1:0] TEMP_MAX = AW'(999);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, PROCESS} state_t;

  state_t         state;
  logic [PW-1:0]  period_cnt;
  logic [DW-1:0]  div_cnt;
  logic [3:0]     bit_cnt;
  logic [15:0]    shift_reg;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  sample_cnt;

  logic           period_wrap;
  logic           div_last;
  logic           frame_fault;
  logic [9:0]     degrees;
  logic [AW-1:0]  acc_next;
  logic [AW-1:0]  avg;
  logic [CW-1:0]  cnt_next;
  logic           unused_bits;

  // Frame word layout: [14:3] is the quarter-degree code, so whole degrees are [14:5].
  assign period_wrap = (period_cnt == PER_LAST);
  assign div_last    = (div_cnt == DIV_LAST);
  assign frame_fault = shift_reg[2];
  assign degrees     = shift_reg[14:5];
  assign acc_next    = acc + AW'(degrees);
  assign cnt_next    = sample_cnt + CW'(1);
  assign avg         = acc_next >> AVG_LOG2;
  assign unused_bits = ^{shift_reg[15], shift_reg[4:3], shift_reg[1:0]};

  // Free-running conversion period counter; the FSM only looks at its wrap while idle.
  always_ff @(posedge clock or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      period_cnt <= '0;
    end else if (period_wrap) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // Frame sequencer: chip select, SCLK generation, bit capture, and decode/average.
  always_ff @(posedge clock or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      acc          <= '0;
      sample_cnt   <= '0;
      temp_out     <= '0;
      temp_valid   <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      case (state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          if (period_wrap && sample_en) begin
            state    <= CS_SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        CS_SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!adc_sclk) begin
              adc_sclk  <= 1'b1;
              shift_reg <= {shift_reg[14:0], adc_miso};
            end else begin
              adc_sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= CS_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        CS_HOLD: begin
          adc_sclk <= 1'b0;
          if (div_last) begin
            div_cnt  <= '0;
            adc_cs_n <= 1'b1;
            state    <= PROCESS;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        PROCESS: begin
          state <= IDLE;
          if (frame_fault) begin
            sensor_fault <= 1'b1;
          end else begin
            sensor_fault <= 1'b0;
            if (cnt_next == CNT_FULL) begin
              temp_out   <= (avg > TEMP_MAX) ? 10'd999 : avg[9:0];
              temp_valid <= 1'b1;
              acc        <= '0;
              sample_cnt <= '0;
            end else begin
              acc        <= acc_next;
              sample_cnt <= cnt_next;
            end
          end
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule
